// File: rtl/adsr_pkg.sv
// rtl/adsr_pkg.sv - state encodings and constants shared by the ADSR envelope blocks
package adsr_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 3'd0,
    ST_A    = 3'd1,
    ST_D    = 3'd2,
    ST_S    = 3'd3,
    ST_R    = 3'd4
  } adsr_state_e;

endpackage

// File: rtl/adsr_chan.sv
// rtl/adsr_chan.sv - one ADSR envelope channel with saturating steps; ADSR_RETRIG_EN enables retrigger from release
module adsr_chan
  import adsr_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_tick,
  input  logic         i_trig,
  input  logic [W-1:0] i_ai,
  input  logic [W-1:0] i_di,
  input  logic [W-1:0] i_s,
  input  logic [W-1:0] i_ri,
  output logic [W-1:0] o_env,
  output logic         o_busy
);

  localparam logic [W:0]   MAX_EXT = {1'b0, {W{1'b1}}};
  localparam logic [W-1:0] MAX_LVL = {W{1'b1}};

  adsr_state_e  r_state;
  logic [W-1:0] r_level;
  logic         r_busy;

  // One guard bit on every step so overflow and borrow are visible instead of wrapping.
  logic [W:0] w_sum;
  logic [W:0] w_dec_d;
  logic [W:0] w_dec_r;

  assign w_sum   = {1'b0, r_level} + {1'b0, i_ai};
  assign w_dec_d = {1'b0, r_level} - {1'b0, i_di};
  assign w_dec_r = {1'b0, r_level} - {1'b0, i_ri};

  // Envelope FSM: one transition and one level update per tick; busy tracks the next state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_level <= '0;
      r_busy  <= 1'b0;
    end else if (i_tick) begin
      r_busy <= 1'b1;
      case (r_state)
        ST_A: begin
          if (!i_trig) begin
            r_state <= ST_R;
          end else if (i_ai == '0 || w_sum >= MAX_EXT) begin
            r_level <= MAX_LVL;
            r_state <= ST_D;
          end else begin
            r_level <= w_sum[W-1:0];
          end
        end
        ST_D: begin
          if (!i_trig) begin
            r_state <= ST_R;
          end else if (i_di == '0 || w_dec_d[W] || w_dec_d[W-1:0] <= i_s) begin
            r_level <= i_s;
            r_state <= ST_S;
          end else begin
            r_level <= w_dec_d[W-1:0];
          end
        end
        ST_S: begin
          // Sustain tracks s live, so a change to s shows up on the very next tick.
          r_level <= i_s;
          if (!i_trig) r_state <= ST_R;
        end
        ST_R: begin
`ifdef ADSR_RETRIG_EN
          if (i_trig) begin
            // Legato: attack resumes from wherever the release had got to.
            r_state <= ST_A;
          end else
`endif
          if (i_ri == '0 || w_dec_r[W] || w_dec_r[W-1:0] == '0) begin
            r_level <= '0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_level <= w_dec_r[W-1:0];
          end
        end
        default: begin
          // IDLE and any stray code: level parks at 0 for the entry tick of an attack.
          r_level <= '0;
          r_busy  <= i_trig;
          r_state <= i_trig ? ST_A : ST_IDLE;
        end
      endcase
    end
  end

  assign o_env  = r_level;
  assign o_busy = r_busy;

endmodule

// File: rtl/adsr_poly.sv
// rtl/adsr_poly.sv - NCH-channel ADSR envelope generator sharing rates and tick; ADSR_RETRIG_EN enables retrigger from release
module adsr_poly
  import adsr_pkg::*;
#(
  parameter int W   = 8,
  parameter int NCH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tick,
  input  logic [NCH-1:0]   trig,
  input  logic [W-1:0]     ai,
  input  logic [W-1:0]     di,
  input  logic [W-1:0]     s,
  input  logic [W-1:0]     ri,
  output logic [NCH*W-1:0] env,
  output logic [NCH-1:0]   busy
);

  // One independent channel per gate; only rates, sustain and tick are shared.
  for (genvar c = 0; c < NCH; c++) begin : g_chan
    adsr_chan #(
      .W(W)
    ) u_chan (
      .clk    (clk),
      .rstn   (rstn),
      .i_tick (tick),
      .i_trig (trig[c]),
      .i_ai   (ai),
      .i_di   (di),
      .i_s    (s),
      .i_ri   (ri),
      .o_env  (env[c*W +: W]),
      .o_busy (busy[c])
    );
  end

endmodule
